proc_display: RTL and testbench

- Downstream consumer of the processor top-level debug outputs: IR_Out, PC_Out, StateO, ALU_A, ALU_B, ALU_Out, RQ0 and Mux_out.
- Snapshots those outputs, lets the user step through them as seven "pages" with a debounced push-button, and time-multiplexes the selected 16-bit word as four hex digits onto a common-anode 4-digit seven-segment display.
- A Hold input freezes all captured values so a single processor state can be inspected.

---
 rtl/proc_display.sv | 151 +++++++++++++++
 tb/tb_proc_display.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_display.sv
// Debug viewer for the processor top level: snapshots the datapath outputs and scans one
// selected 16-bit word as four hex digits onto a common-anode seven-segment display.
module proc_display #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned DEBOUNCE    = 1000000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] IR_Out,
  input  logic [4:0]  PC_Out,
  input  logic [3:0]  StateO,
  input  logic [15:0] ALU_A,
  input  logic [15:0] ALU_B,
  input  logic [15:0] ALU_Out,
  input  logic [15:0] RQ0,
  input  logic [15:0] Mux_out,
  input  logic        Page_btn,
  input  logic        Hold,
  output logic [3:0]  An,
  output logic [6:0]  Seg,
  output logic        Dp,
  output logic [2:0]  Page
);

  localparam int unsigned RefW = $clog2(REFRESH_DIV);
  localparam int unsigned DbW  = $clog2(DEBOUNCE);

  logic [RefW-1:0] ref_q;
  logic [1:0]      digit_q;
  logic [DbW-1:0]  db_q;
  logic            sync1_q, sync2_q, stable_q;
  logic [2:0]      page_q;
  logic [15:0]     snap_q [7];
  logic [15:0]     src    [7];
  logic [15:0]     word;
  logic [3:0]      nibble;
  logic [6:0]      seg_d;
  logic [3:0]      an_q;
  logic [6:0]      seg_q;
  logic            dp_q;

  always_comb begin
    src[0] = IR_Out;
    src[1] = {3'b000, PC_Out, 4'h0, StateO};
    src[2] = ALU_A;
    src[3] = ALU_B;
    src[4] = ALU_Out;
    src[5] = RQ0;
    src[6] = Mux_out;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 7; i++) snap_q[i] <= '0;
    end else if (!Hold) begin
      for (int i = 0; i < 7; i++) snap_q[i] <= src[i];
    end
  end

  // Page advances on the edge that accepts a debounced 0->1 level change.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      db_q     <= '0;
      page_q   <= 3'd0;
    end else begin
      sync1_q <= Page_btn;
      sync2_q <= sync1_q;
      if (sync2_q == stable_q) begin
        db_q <= '0;
      end else if (db_q == DbW'(DEBOUNCE - 1)) begin
        stable_q <= sync2_q;
        db_q     <= '0;
        if (sync2_q) page_q <= (page_q == 3'd6) ? 3'd0 : page_q + 3'd1;
      end else begin
        db_q <= db_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ref_q   <= '0;
      digit_q <= 2'd0;
    end else if (ref_q == RefW'(REFRESH_DIV - 1)) begin
      ref_q   <= '0;
      digit_q <= digit_q + 2'd1;
    end else begin
      ref_q <= ref_q + 1'b1;
    end
  end

  always_comb begin
    word = 16'h0000;
    case (page_q)
      3'd0:    word = snap_q[0];
      3'd1:    word = snap_q[1];
      3'd2:    word = snap_q[2];
      3'd3:    word = snap_q[3];
      3'd4:    word = snap_q[4];
      3'd5:    word = snap_q[5];
      3'd6:    word = snap_q[6];
      default: word = 16'h0000;
    endcase
    nibble = word[{digit_q, 2'b00} +: 4];
  end

  always_comb begin
    seg_d = 7'h7f;
    case (nibble)
      4'h0: seg_d = 7'h40;
      4'h1: seg_d = 7'h79;
      4'h2: seg_d = 7'h24;
      4'h3: seg_d = 7'h30;
      4'h4: seg_d = 7'h19;
      4'h5: seg_d = 7'h12;
      4'h6: seg_d = 7'h02;
      4'h7: seg_d = 7'h78;
      4'h8: seg_d = 7'h00;
      4'h9: seg_d = 7'h10;
      4'hA: seg_d = 7'h08;
      4'hB: seg_d = 7'h03;
      4'hC: seg_d = 7'h46;
      4'hD: seg_d = 7'h21;
      4'hE: seg_d = 7'h06;
      4'hF: seg_d = 7'h0E;
      default: seg_d = 7'h7f;
    endcase
  end

  // Registered together so anode, segments and point never disagree by a cycle.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      an_q  <= 4'b1110;
      seg_q <= 7'h40;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= ~(4'b0001 << digit_q);
      seg_q <= seg_d;
      dp_q  <= ~((digit_q == 2'd0) & Hold);
    end
  end

  assign An   = an_q;
  assign Seg  = seg_q;
  assign Dp   = dp_q;
  assign Page = page_q;

endmodule

// File: tb/tb_proc_display.sv
// Scoreboard bench for proc_display: stimulus queues expected display/page values per cycle,
// a negedge monitor pops and compares them.
module tb_proc_display;

  localparam int unsigned RefDiv = 4;
  localparam int unsigned Deb    = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] ir = 16'h1A2F;
  logic [4:0]  pc = 5'h00;
  logic [3:0]  st = 4'h0;
  logic [15:0] alu_a = 16'h1111;
  logic [15:0] alu_b = 16'h2222;
  logic [15:0] alu_out = 16'h00FF;
  logic [15:0] rq0 = 16'hBEEF;
  logic [15:0] mux = 16'h3333;
  logic        btn = 1'b0;
  logic        hold = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [2:0]  page;

  proc_display #(.REFRESH_DIV(RefDiv), .DEBOUNCE(Deb)) dut (
    .Clk(clk), .Reset(rst_n), .IR_Out(ir), .PC_Out(pc), .StateO(st), .ALU_A(alu_a),
    .ALU_B(alu_b), .ALU_Out(alu_out), .RQ0(rq0), .Mux_out(mux), .Page_btn(btn), .Hold(hold),
    .An(an), .Seg(seg), .Dp(dp), .Page(page)
  );

  always #5 clk = ~clk;

  // Number of rising edges since reset release.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    int         cyc;
    bit         cd;
    bit         cp;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] page;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   total = 0;
  int   bad = 0;

  logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      me = q.pop_front();
      if (me.cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL %s: check due at cycle %0d missed (now %0d)", me.name, me.cyc, cyc);
      end else begin
        if (me.cd) begin
          total++;
          if ({an, seg, dp} !== {me.an, me.seg, me.dp}) begin
            bad++;
            $display("FAIL %s @%0d: got An=%b Seg=%h Dp=%b, want An=%b Seg=%h Dp=%b",
                     me.name, cyc, an, seg, dp, me.an, me.seg, me.dp);
          end
        end
        if (me.cp) begin
          total++;
          if (page !== me.page) begin
            bad++;
            $display("FAIL %s @%0d: got Page=%0d, want %0d", me.name, cyc, page, me.page);
          end
        end
      end
    end
  end

  function automatic int digit_at(int k);
    return ((k - 1) / 4) % 4;
  endfunction

  function automatic int next_k(int start, int d);
    int k = start;
    while (digit_at(k) != d) k++;
    return k;
  endfunction

  task automatic push_raw(string name, int k, logic [3:0] a, logic [6:0] s, logic d,
                          bit cp, logic [2:0] p);
    exp_t e;
    e.cyc = k; e.cd = 1'b1; e.cp = cp; e.an = a; e.seg = s; e.dp = d; e.page = p; e.name = name;
    q.push_back(e);
  endtask

  // Expected outputs after edge k, given the word and Hold level seen at that edge.
  task automatic push_disp(string name, int k, logic [15:0] w, logic h);
    int d;
    logic [3:0] nib;
    logic [3:0] a;
    d = digit_at(k);
    nib = w[4*d +: 4];
    a = 4'b1111;
    a[d] = 1'b0;
    push_raw(name, k, a, dec[nib], !(d == 0 && h), 1'b0, 3'd0);
  endtask

  task automatic push_page(string name, int k, logic [2:0] p);
    exp_t e;
    e.cyc = k; e.cd = 1'b0; e.cp = 1'b1; e.an = '0; e.seg = '0; e.dp = 1'b0; e.page = p;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic wait_cyc(int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic chk_page(string name, logic [2:0] p);
    int t;
    t = cyc + 1;
    push_page(name, t, p);
    wait_cyc(t);
  endtask

  task automatic disp_at(string name, int d, logic [15:0] w, logic h);
    int k;
    k = next_k(cyc + 1, d);
    push_disp(name, k, w, h);
    wait_cyc(k);
  endtask

  task automatic press(int hi);
    btn = 1'b1;
    repeat (hi) @(negedge clk);
    btn = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout: simulation did not complete, got still running, want done");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int c;
    // Reset values while held in reset.
    push_raw("reset_state", 0, 4'b1110, 7'h40, 1'b1, 1'b1, 3'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // First edge shows the cleared snapshot; scan then walks F,2,A,1 of 1A2F.
    push_raw("release_k1", 1, 4'b1110, 7'h40, 1'b1, 1'b0, 3'd0);
    push_raw("scan_d0_first", 2, 4'b1110, 7'h0E, 1'b1, 1'b0, 3'd0);
    push_raw("scan_d0_last", 4, 4'b1110, 7'h0E, 1'b1, 1'b0, 3'd0);
    push_raw("scan_d1", 5, 4'b1101, 7'h24, 1'b1, 1'b0, 3'd0);
    push_raw("scan_d2", 9, 4'b1011, 7'h08, 1'b1, 1'b0, 3'd0);
    push_raw("scan_d3", 13, 4'b0111, 7'h79, 1'b1, 1'b0, 3'd0);
    push_raw("scan_wrap", 17, 4'b1110, 7'h0E, 1'b1, 1'b0, 3'd0);
    wait_cyc(17);

    press(2);
    chk_page("glitch_ignored", 3'd0);
    press(10);
    chk_page("long_press_once", 3'd1);

    pc = 5'h13;
    st = 4'h9;
    @(negedge clk);
    disp_at("page1_d3", 3, 16'h1309, 1'b0);
    disp_at("page1_d0", 0, 16'h1309, 1'b0);

    press(6);
    press(6);
    press(6);
    chk_page("to_page4", 3'd4);
    disp_at("p4_live_d1", 1, 16'h00FF, 1'b0);

    hold = 1'b1;
    @(negedge clk);
    alu_out = 16'h1234;
    rq0 = 16'h5A5A;
    @(negedge clk);
    disp_at("hold_d0", 0, 16'h00FF, 1'b1);
    disp_at("hold_d2", 2, 16'h00FF, 1'b1);
    press(6);
    chk_page("held_page5", 3'd5);
    disp_at("held_rq0_d0", 0, 16'hBEEF, 1'b1);
    disp_at("held_rq0_d3", 3, 16'hBEEF, 1'b1);

    hold = 1'b0;
    c = cyc;
    push_disp("unhold_k1_old", c + 1, 16'hBEEF, 1'b0);
    push_disp("unhold_k2_new", c + 2, 16'h5A5A, 1'b0);
    wait_cyc(c + 2);

    press(6);
    chk_page("to_page6", 3'd6);
    press(6);
    chk_page("wrap_to_0", 3'd0);
    for (int i = 1; i <= 7; i++) begin
      press(6);
      chk_page($sformatf("seq_press%0d", i), 3'((i) % 7));
    end
    press(6);
    press(6);
    press(6);
    chk_page("to_page3", 3'd3);

    // Reset mid-scan with the button held across it.
    @(negedge clk);
    btn = 1'b1;
    #2;
    rst_n = 1'b0;
    push_raw("midscan_reset", 0, 4'b1110, 7'h40, 1'b1, 1'b1, 3'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push_raw("rel2_k1", 1, 4'b1110, 7'h40, 1'b1, 1'b1, 3'd0);
    push_disp("rel2_k2", 2, 16'h1A2F, 1'b0);
    push_disp("rel2_k4", 4, 16'h1A2F, 1'b0);
    push_page("requal_not_yet", 4, 3'd0);
    push_disp("rel2_k5", 5, 16'h1A2F, 1'b0);
    push_page("requal_inc", 5, 3'd1);
    push_page("held_no_second", 25, 3'd1);
    wait_cyc(25);
    btn = 1'b0;

    c = 0;
    while (q.size() > 0 && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d checks left pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
